// File: rtl/vr_skid_pipe.sv
// vr_skid_pipe: valid/ready pipeline built from STAGES cascaded skid-buffer
// stages. Every stage registers both data and ready, so in_ready never
// depends combinationally on out_ready. Full throughput, capacity 2*STAGES.
//
// Parameters:
//   WIDTH   payload width (>=1)
//   STAGES  number of cascaded skid stages (>=1)
//
// Ports:
//   clk, rst_n          clock (posedge), async active-low reset
//   flush               synchronous flush, discards all buffered words
//   in_valid/in_ready   upstream handshake, wdata payload
//   out_valid/out_ready downstream handshake, rdata payload
//   occ                 entry count (only with VR_SKID_PIPE_OCC_EN defined)
//
// Optional feature macro: VR_SKID_PIPE_OCC_EN adds the registered occ port.

// One skid stage: main register feeds the output, skid register catches the
// word that arrives in the cycle downstream stalls.
module vr_skid_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic [WIDTH-1:0] din,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic [WIDTH-1:0] dout
);
   // state[0] is m_valid, state[1] is s_valid
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      BUSY  = 2'b01,
      FULL  = 2'b11
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] m_data;
   logic [WIDTH-1:0] s_data;
   logic             m_valid;
   logic             s_valid;
   logic             in_fire;
   logic             out_fire;

   assign m_valid    = state[0];
   assign s_valid    = state[1];
   assign din_ready  = ~s_valid;
   assign dout_valid = m_valid;
   assign dout       = m_data;
   assign in_fire    = din_valid & ~s_valid;
   assign out_fire   = m_valid & dout_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         m_data <= '0;
         s_data <= '0;
      end else if (flush) begin
         // data registers intentionally keep their contents
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: if (in_fire) begin
               state  <= BUSY;
               m_data <= din;
            end
            BUSY: case ({in_fire, out_fire})
               2'b11: m_data <= din;
               2'b10: begin
                  state  <= FULL;
                  s_data <= din;
               end
               2'b01: state <= EMPTY;
               default: ;
            endcase
            FULL: if (out_fire) begin
               state  <= BUSY;
               m_data <= s_data;
            end
            default: state <= EMPTY;
         endcase
      end
   end

   a_no_skid_without_main: assert property (@(posedge clk) disable iff (!rst_n)
      !(s_valid && !m_valid));
endmodule

module vr_skid_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] wdata,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] rdata
`ifdef VR_SKID_PIPE_OCC_EN
   ,
   output logic [$clog2(2*STAGES+1)-1:0] occ
`endif
);
   if (STAGES < 1) begin : g_bad_stages
      $error("vr_skid_pipe: STAGES must be >= 1");
   end

   // Link k connects stage k-1 output to stage k input.
   logic [STAGES:0]            vld;
   logic [STAGES:0]            rdy;
   logic [STAGES:0][WIDTH-1:0] dat;

   assign vld[0]      = in_valid;
   assign dat[0]      = wdata;
   assign rdy[STAGES] = out_ready;

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      vr_skid_stage #(.WIDTH(WIDTH)) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (flush),
         .din_valid (vld[g]),
         .din_ready (rdy[g]),
         .din       (dat[g]),
         .dout_valid(vld[g+1]),
         .dout_ready(rdy[g+1]),
         .dout      (dat[g+1])
      );
   end

   // Stage 0 ready is a flop; flush only masks it so nothing is taken in
   // the flush cycle.
   assign in_ready  = rdy[0] & ~flush;
   assign out_valid = vld[STAGES];
   assign rdata     = dat[STAGES];

`ifdef VR_SKID_PIPE_OCC_EN
   localparam int OCC_W = $clog2(2*STAGES+1);
   logic in_fire;
   logic out_fire;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ <= '0;
      end else if (flush) begin
         occ <= '0;
      end else begin
         case ({in_fire, out_fire})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: ;
         endcase
      end
   end
`endif
endmodule

// File: tb/tb_vr_skid_pipe.sv
// Bench for vr_skid_pipe: three instances (STAGES=1,2,3) share stimulus;
// sel routes in_valid to one instance and picks which outputs the
// scoreboard monitor watches. Expected words are queued when accepted and
// popped by the monitor on every out_fire.
module tb_vr_skid_pipe;
   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_v;
   logic [31:0] wd;
   logic        o_rdy;
   logic [1:0]  sel;

   logic [2:0]  ir_a;
   logic [2:0]  ov_a;
   logic [31:0] rd_a [3];

   logic        cur_ir;
   logic        cur_ov;
   logic [31:0] cur_rd;

   int total = 0;
   int bad   = 0;
   int out_cnt = 0;
   logic [31:0] exp_q [$];

   bit          prev_stall = 0;
   logic [31:0] prev_rd    = '0;

`ifdef VR_SKID_PIPE_OCC_EN
   logic [3:0] occ_a [3];
   logic [3:0] cur_occ;
   assign cur_occ = occ_a[sel];
`endif

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int S = g + 1;
`ifdef VR_SKID_PIPE_OCC_EN
      localparam int OW = $clog2(2*S+1);
      logic [OW-1:0] occ_l;
      assign occ_a[g] = 4'(occ_l);
`endif
      vr_skid_pipe #(.WIDTH(32), .STAGES(S)) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .flush    (flush),
         .in_valid (in_v && (sel == 2'(g))),
         .in_ready (ir_a[g]),
         .wdata    (wd),
         .out_valid(ov_a[g]),
         .out_ready(o_rdy),
         .rdata    (rd_a[g])
`ifdef VR_SKID_PIPE_OCC_EN
         ,
         .occ      (occ_l)
`endif
      );
   end

   assign cur_ir = ir_a[sel];
   assign cur_ov = ov_a[sel];
   assign cur_rd = rd_a[sel];

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 0;
      end else begin
         if (prev_stall && cur_ov)
            chk("rdata_stable", cur_rd, prev_rd);
         if (cur_ov && o_rdy) begin
            out_cnt++;
            if (exp_q.size() == 0) chk("unexpected_word", cur_rd, 32'hxxxx_xxxx);
            else                   chk("data", cur_rd, exp_q.pop_front());
         end
         prev_stall = cur_ov && !o_rdy;
         prev_rd    = cur_rd;
      end
   end

   // Offer one word; lat >= 0 also checks edges from accept to out_valid.
   task automatic send(input logic [31:0] w, input int lat);
      bit got;
      int n;
      @(posedge clk); #1;
      in_v = 1; wd = w; got = 0;
      for (int t = 0; t < 50 && !got; t++) begin
         @(negedge clk);
         if (cur_ir) begin
            exp_q.push_back(w);
            got = 1;
         end else begin
            @(posedge clk); #1;
         end
      end
      chk("accept", 32'(got), 32'd1);
      @(posedge clk); #1;
      in_v = 0;
      if (lat >= 0) begin
         n = 1;
         @(negedge clk);
         while (!cur_ov && n < 20) begin
            n++;
            @(negedge clk);
         end
         chk("latency", 32'(n), 32'(lat));
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 500 && exp_q.size() != 0; t++) begin
         @(negedge clk); #1;
      end
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   bit rnd_done;

   initial begin
      int n;
      int c0;
      sel = 2'd1; flush = 0; in_v = 0; wd = '0; o_rdy = 1;
      rst_n = 1;
      #1 rst_n = 0;
      #2;
      chk("rst_out_valid", 32'(cur_ov), 32'd0);
      chk("rst_rdata", cur_rd, 32'd0);
      chk("rst_in_ready", 32'(cur_ir), 32'd1);
`ifdef VR_SKID_PIPE_OCC_EN
      chk("rst_occ", 32'(cur_occ), 32'd0);
`endif
      #20 rst_n = 1;

      // Back-to-back stream through STAGES=2 with out_ready=1
      @(posedge clk); #1;
      in_v = 1; wd = 32'd1;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         chk("stream_in_ready", 32'(cur_ir), 32'd1);
         if (cur_ir) exp_q.push_back(wd);
         if (i == 2) chk("stream_lat_early", 32'(cur_ov), 32'd0);
         if (i == 3) chk("stream_lat_first", 32'(cur_ov), 32'd1);
         @(posedge clk); #1;
         wd = 32'(i + 1);
      end
      in_v = 0;
      drain();

      // Backpressure: exactly 2*STAGES words fit
      @(posedge clk); #1;
      o_rdy = 0; in_v = 1; wd = 32'hA0; n = 0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (!cur_ir) break;
         exp_q.push_back(wd);
         n++;
         @(posedge clk); #1;
         wd = wd + 1;
      end
      in_v = 0;
      chk("bp_accepted", 32'(n), 32'd4);
      repeat (3) @(negedge clk);
      chk("bp_in_ready_low", 32'(cur_ir), 32'd0);
      chk("bp_head", cur_rd, 32'hA0);
`ifdef VR_SKID_PIPE_OCC_EN
      chk("bp_occ_full", 32'(cur_occ), 32'd4);
`endif
      @(posedge clk); #1;
      o_rdy = 1;
      drain();
`ifdef VR_SKID_PIPE_OCC_EN
      chk("bp_occ_empty", 32'(cur_occ), 32'd0);
`endif

      // Flush with a competing input word
      o_rdy = 0;
      send(32'h11, -1);
      send(32'h22, -1);
      send(32'h33, -1);
      @(posedge clk); #1;
      in_v = 1; wd = 32'hDEAD; flush = 1;
      @(negedge clk);
      chk("flush_in_ready", 32'(cur_ir), 32'd0);
      @(posedge clk); #1;
      flush = 0; in_v = 0;
      exp_q.delete();
      @(negedge clk);
      chk("flush_out_valid", 32'(cur_ov), 32'd0);
`ifdef VR_SKID_PIPE_OCC_EN
      chk("flush_occ", 32'(cur_occ), 32'd0);
`endif
      o_rdy = 1;
      repeat (3) @(negedge clk);
      send(32'hBEEF, 2);
      drain();

      // Async reset mid-stream
      o_rdy = 0;
      send(32'h55, -1);
      send(32'h66, -1);
      for (int t = 0; t < 20 && !cur_ov; t++) @(negedge clk);
      chk("pre_rst_out_valid", 32'(cur_ov), 32'd1);
      @(posedge clk); #1;
      rst_n = 0;
      #1;
      chk("mid_rst_out_valid", 32'(cur_ov), 32'd0);
      chk("mid_rst_rdata", cur_rd, 32'd0);
      chk("mid_rst_in_ready", 32'(cur_ir), 32'd1);
`ifdef VR_SKID_PIPE_OCC_EN
      chk("mid_rst_occ", 32'(cur_occ), 32'd0);
`endif
      exp_q.delete();
      @(negedge clk); #1;
      rst_n = 1;
      o_rdy = 1;
      send(32'h77, 2);
      drain();

      // Random traffic on STAGES=3
      @(posedge clk); #1;
      sel = 2'd2;
      rnd_done = 0;
      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               bit got;
               @(posedge clk); #1;
               in_v = 0;
               while ($urandom_range(0, 1) == 1) begin
                  @(posedge clk); #1;
               end
               in_v = 1; wd = $urandom; got = 0;
               for (int t = 0; t < 100 && !got; t++) begin
                  @(negedge clk);
                  if (cur_ir) begin
                     exp_q.push_back(wd);
                     got = 1;
                  end else begin
                     @(posedge clk); #1;
                  end
               end
               if (!got) chk("rnd_accept_timeout", 32'd0, 32'd1);
            end
            @(posedge clk); #1;
            in_v = 0;
            drain();
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               logic ir_b;
               @(posedge clk); #2;
               o_rdy = 1'($urandom_range(0, 1));
               ir_b  = cur_ir;
               o_rdy = ~o_rdy;
               #1;
               chk("in_ready_not_comb", 32'(cur_ir), 32'(ir_b));
               o_rdy = ~o_rdy;
            end
         end
      join
      o_rdy = 1;

      // STAGES=1 with out_ready alternating
      @(posedge clk); #1;
      sel = 2'd0; o_rdy = 1; in_v = 1; wd = 32'h100;
      c0 = out_cnt;
      for (int i = 0; i < 40; i++) begin
         bit pushed;
         pushed = 0;
         @(negedge clk);
         if (cur_ir) begin
            exp_q.push_back(wd);
            pushed = 1;
         end
         @(posedge clk); #1;
         if (pushed) wd = wd + 1;
         o_rdy = ~o_rdy;
      end
      in_v = 0;
      n = out_cnt - c0;
      chk("alt_rate", 32'(n >= 18 && n <= 20), 32'd1);
      o_rdy = 1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vr_skid_pipe.md
Name: vr_skid_pipe

Overview:
- Parametrised valid/ready pipeline of STAGES cascaded skid-buffer stages. It is the successor to the single-stage pipeline register.
- Every stage registers both the data path and the ready path, so in_ready has no combinational path from out_ready. This lets long handshake chains close timing at full throughput.
- Adds a synchronous flush. Sits between any two streaming blocks in the datapath, for example at a clock-region crossing point or in front of long routing.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- STAGES, 2, number of cascaded skid stages (>=1; 0 is illegal and must trigger an elaboration-time error).

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous flush; discards all buffered entries.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  upstream may transfer; registered, no combinational path from out_ready.
- wdata  input  WIDTH  upstream payload.
- out_valid  output  1  downstream data valid; registered.
- out_ready  input  1  downstream accepts.
- rdata  output  WIDTH  downstream payload; registered.

Behaviour:
- Transfer rules: a transfer occurs at a posedge when valid&&ready. in_fire = in_valid&&in_ready. out_fire = out_valid&&out_ready.
- Stage structure: each stage k has a main register (m_valid, m_data) and a skid register (s_valid, s_data).
  - Stage output valid = m_valid. Stage output data = m_data.
  - Stage input ready = ~s_valid (a flop, not decoded from downstream).
  - Stage k input = stage k-1 output; stage 0 input = in_valid/wdata; stage STAGES-1 output = out_valid/rdata.
- Per-stage state machine. States: EMPTY (m=0,s=0), BUSY (m=1,s=0), FULL (m=1,s=1).
  - EMPTY: in_fire -> BUSY, m_data<=din.
  - BUSY: in_fire & out_fire -> BUSY, m_data<=din.
  - BUSY: in_fire & ~out_fire -> FULL, s_data<=din.
  - BUSY: ~in_fire & out_fire -> EMPTY.
  - FULL: ready=0. out_fire -> BUSY, m_data<=s_data. No input can fire in FULL.
  - m=0,s=1 is unreachable; assert it never occurs.
- in_ready = ~s_valid[0] & ~flush.
- Latency: a word accepted at edge T appears on out_valid/rdata after edge T+STAGES-1 when all stages are empty. For STAGES=1, rdata is valid in the cycle after acceptance.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Capacity: 2*STAGES words.
- Ordering: strict FIFO order. No word is dropped or duplicated.
- Backpressure: when out_ready deasserts, in_ready falls at most one cycle later per stage. In-flight words land in skid registers.
- Stability: once out_valid=1, rdata holds stable until out_fire.
- Flush: at a posedge with flush=1, all m_valid/s_valid <= 0.
  - in_ready=0 in the flush cycle, so no input is accepted.
  - An out_fire in the flush cycle still counts as consumed.
  - Data registers are not cleared.
  - flush held for multiple cycles keeps the pipe empty.
- Reset (async assert, any time, including mid-transfer):
  - All valid flops = 0, all data registers = 0.
  - out_valid=0, rdata=0, in_ready=1.
  - Release is synchronous to clk at the next posedge.
- Simultaneous in_fire and out_fire on a full-rate stream: occupancy is unchanged.
- Simultaneous flush and in_valid: input is not accepted.

Optional Feature:
- Macro: VR_SKID_PIPE_OCC_EN.
- When defined, adds output port occ [$clog2(2*STAGES+1)-1:0]: a registered count of valid entries across all stages.
  - occ = sum of all m_valid+s_valid. It is maintained incrementally: +1 on in_fire, -1 on out_fire, unchanged on both.
  - occ = 0 on reset and after a flush edge.
  - Never exceeds 2*STAGES.
- When undefined, the port and counter logic are absent. Behaviour is otherwise identical.

Test Plan:
- STAGES=2, WIDTH=32, out_ready=1: stream 0x1..0x10 back-to-back.
  - First out_valid appears 2 cycles after the first accept.
  - Outputs arrive in order, one per cycle, and in_ready stays 1.
- STAGES=2, out_ready=0: push until in_ready=0.
  - Exactly 4 words are accepted (0xA0..0xA3).
  - Raising out_ready drains A0..A3 in order.
  - occ=4 while stalled, then 0 after draining (OCC_EN).
- Random in_valid/out_ready at 50%/50%, 10k words, STAGES=3:
  - Scoreboard shows no loss, duplication, or reordering.
  - rdata is stable whenever out_valid&&~out_ready.
  - in_ready is never combinational on out_ready (checked with a zero-delay toggle).
- Fill 3 words, then assert flush for 1 cycle with in_valid=1 and wdata=0xDEAD:
  - out_valid=0 next cycle, 0xDEAD is not accepted, occ=0.
  - Subsequent word 0xBEEF exits normally.
- Assert rst_n low mid-stream while out_valid=1:
  - out_valid=0 and rdata=0 immediately, in_ready=1.
  - After release, the first new word exits with the nominal latency.
- STAGES=1, alternate out_ready 1/0 each cycle with in_valid=1: average 0.5 word/cycle and ordered output.
